// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, ALU operation
// classes, datapath mux selects and base opcodes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBranch,
    StJal,
    StJalr,
    StLink,
    StLui,
    StAuipc,
    StTrap
  } state_e;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } alu_op_e;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAnd  = 4'b0010;
  localparam logic [3:0] AluOr   = 4'b0011;
  localparam logic [3:0] AluXor  = 4'b0100;
  localparam logic [3:0] AluSlt  = 4'b0101;
  localparam logic [3:0] AluSltu = 4'b0110;
  localparam logic [3:0] AluSll  = 4'b0111;
  localparam logic [3:0] AluSrl  = 4'b1000;
  localparam logic [3:0] AluSra  = 4'b1001;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmJ = 3'b011;
  localparam logic [2:0] ImmU = 3'b100;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;
  localparam logic [1:0] SrcAZero  = 2'b11;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  // Unknown opcodes fall back to I-format; they never reach a state that uses it.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OpStore:         imm_src_of = ImmS;
      OpBranch:        imm_src_of = ImmB;
      OpJal:           imm_src_of = ImmJ;
      OpLui, OpAuipc:  imm_src_of = ImmU;
      default:         imm_src_of = ImmI;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle. The controller is the master: it consumes IR
// fields, ALU flags and memory ready, and drives every enable and mux select.
interface mc_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic             zero;
  logic             lt;
  logic             ltu;
  logic             mem_ready;

  logic             pc_write;
  logic             ir_write;
  logic             adr_src;
  logic             mem_req;
  logic             mem_write;
  logic             reg_write;
  logic [1:0]       result_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       imm_src;
  logic [3:0]       alu_control;
  logic             illegal_instr;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, funct3, funct7b5, zero, lt, ltu, mem_ready,
    output pc_write, ir_write, adr_src, mem_req, mem_write, reg_write,
    output result_src, alu_src_a, alu_src_b, imm_src, alu_control,
    output illegal_instr, instret
  );

  modport slave (
    output op, funct3, funct7b5, zero, lt, ltu, mem_ready,
    input  pc_write, ir_write, adr_src, mem_req, mem_write, reg_write,
    input  result_src, alu_src_a, alu_src_b, imm_src, alu_control,
    input  illegal_instr, instret
  );
endinterface

// File: rtl/mc_alu_decoder.sv
// Combinational ALU operation decoder: maps the FSM's ALU operation class plus
// instruction fields to the ALU control code.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  alu_op_e    i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_op5,
  output logic [3:0] o_alu_control
);

  always_comb begin
    o_alu_control = AluAdd;
    case (i_alu_op)
      AluOpAdd: o_alu_control = AluAdd;
      AluOpSub: o_alu_control = AluSub;
      AluOpFunct: begin
        unique case (i_funct3)
          // bit 30 only means SUB for register-register ops; for ADDI it is immediate data
          3'b000:  o_alu_control = (i_op5 && i_funct7b5) ? AluSub : AluAdd;
          3'b001:  o_alu_control = AluSll;
          3'b010:  o_alu_control = AluSlt;
          3'b011:  o_alu_control = AluSltu;
          3'b100:  o_alu_control = AluXor;
          3'b101:  o_alu_control = i_funct7b5 ? AluSra : AluSrl;
          3'b110:  o_alu_control = AluOr;
          3'b111:  o_alu_control = AluAnd;
          default: o_alu_control = AluAdd;
        endcase
      end
      default: o_alu_control = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I controller: Moore FSM sequencing a shared-ALU/shared-memory
// datapath, with memory ready handshake, branch resolution, trapping and instret.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter bit          TRAP_EN       = 1'b1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  mc_ctrl_if.master    bus
);

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_instret;
  logic             r_illegal;

  logic             w_ready;
  logic             w_take;
  logic             w_bad;
  logic             w_pc_write;
  logic             w_ir_write;
  logic             w_adr_src;
  logic             w_mem_req;
  logic             w_mem_write;
  logic             w_reg_write;
  logic [1:0]       w_result_src;
  logic [1:0]       w_src_a;
  logic [1:0]       w_src_b;
  alu_op_e          w_alu_op;
  logic [3:0]       w_alu_control;

  assign w_ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  always_comb begin
    w_take = 1'b0;
    case (bus.funct3)
      3'b000:  w_take = bus.zero;
      3'b001:  w_take = !bus.zero;
      3'b100:  w_take = bus.lt;
      3'b101:  w_take = !bus.lt;
      3'b110:  w_take = bus.ltu;
      3'b111:  w_take = !bus.ltu;
      default: w_take = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    w_bad  = 1'b0;
    unique case (r_state)
      StFetch:    if (w_ready) w_next = StDecode;
      StDecode: begin
        case (bus.op)
          OpLoad, OpStore: w_next = StMemAdr;
          OpReg:           w_next = StExecR;
          OpImm:           w_next = StExecI;
          OpBranch: begin
            if (bus.funct3[2:1] == 2'b01) w_bad = 1'b1;
            else                          w_next = StBranch;
          end
          OpJal:           w_next = StJal;
          OpJalr:          w_next = StJalr;
          OpLui:           w_next = StLui;
          OpAuipc:         w_next = StAuipc;
          default:         w_bad = 1'b1;
        endcase
        // Without trapping, an illegal instruction retires as a NOP.
        if (w_bad) w_next = TRAP_EN ? StTrap : StFetch;
      end
      StMemAdr:   w_next = (bus.op == OpStore) ? StMemWrite : StMemRead;
      StMemRead:  if (w_ready) w_next = StMemWb;
      StMemWb:    w_next = StFetch;
      StMemWrite: if (w_ready) w_next = StFetch;
      StExecR:    w_next = StAluWb;
      StExecI:    w_next = StAluWb;
      StAluWb:    w_next = StFetch;
      StBranch:   w_next = StFetch;
      StJal:      w_next = StAluWb;
      StJalr:     w_next = StLink;
      StLink:     w_next = StAluWb;
      StLui:      w_next = StAluWb;
      StAuipc:    w_next = StAluWb;
      StTrap:     w_next = StTrap;
      default:    w_next = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StFetch;
      r_instret <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state != StFetch && w_next == StFetch) r_instret <= r_instret + CNT_W'(1);
      if (w_next == StTrap) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_req    = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_result_src = ResAluOut;
    w_src_a      = SrcAPc;
    w_src_b      = SrcBRs2;
    w_alu_op     = AluOpAdd;
    unique case (r_state)
      StFetch: begin
        w_mem_req    = 1'b1;
        w_src_b      = SrcBFour;
        w_result_src = ResAluResult;
        w_ir_write   = w_ready;
        w_pc_write   = w_ready;
      end
      StDecode: begin
        w_src_a = SrcAOldPc;
        w_src_b = SrcBImm;
      end
      StMemAdr: begin
        w_src_a = SrcARs1;
        w_src_b = SrcBImm;
      end
      StMemRead: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
      end
      StMemWb: begin
        w_result_src = ResData;
        w_reg_write  = 1'b1;
      end
      StMemWrite: begin
        w_mem_req   = 1'b1;
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      StExecR: begin
        w_src_a  = SrcARs1;
        w_alu_op = AluOpFunct;
      end
      StExecI: begin
        w_src_a  = SrcARs1;
        w_src_b  = SrcBImm;
        w_alu_op = AluOpFunct;
      end
      StAluWb:    w_reg_write = 1'b1;
      StBranch: begin
        w_src_a    = SrcARs1;
        w_alu_op   = AluOpSub;
        w_pc_write = w_take;
      end
      StJal: begin
        w_src_a    = SrcAOldPc;
        w_src_b    = SrcBFour;
        w_pc_write = 1'b1;
      end
      StJalr: begin
        w_src_a      = SrcARs1;
        w_src_b      = SrcBImm;
        w_result_src = ResAluResult;
        w_pc_write   = 1'b1;
      end
      StLink: begin
        w_src_a = SrcAOldPc;
        w_src_b = SrcBFour;
      end
      StLui: begin
        w_src_a = SrcAZero;
        w_src_b = SrcBImm;
      end
      StAuipc: begin
        w_src_a = SrcAOldPc;
        w_src_b = SrcBImm;
      end
      StTrap:     ;
      default:    ;
    endcase
  end

  mc_alu_decoder u_alu_dec (
    .i_alu_op      (w_alu_op),
    .i_funct3      (bus.funct3),
    .i_funct7b5    (bus.funct7b5),
    .i_op5         (bus.op[5]),
    .o_alu_control (w_alu_control)
  );

  // Enables are masked by reset so an in-flight write drops the instant reset asserts.
  assign bus.pc_write      = reset_n & w_pc_write;
  assign bus.ir_write      = reset_n & w_ir_write;
  assign bus.mem_req       = reset_n & w_mem_req;
  assign bus.mem_write     = reset_n & w_mem_write;
  assign bus.reg_write     = reset_n & w_reg_write;
  assign bus.adr_src       = w_adr_src;
  assign bus.result_src    = w_result_src;
  assign bus.alu_src_a     = w_src_a;
  assign bus.alu_src_b     = w_src_b;
  assign bus.alu_control   = w_alu_control;
  assign bus.imm_src       = imm_src_of(bus.op);
  assign bus.illegal_instr = r_illegal;
  assign bus.instret       = r_instret;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: a trapping controller and a non-trapping 2-bit-counter controller
// run the same instruction stream; per-cycle output vectors are checked by hand values.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       lt;
  logic       ltu;
  logic       mem_ready;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  mc_ctrl_if #(.CNT_W(32)) bus0 ();
  mc_ctrl_if #(.CNT_W(2))  bus1 ();

  assign bus0.op = op;
  assign bus0.funct3 = funct3;
  assign bus0.funct7b5 = funct7b5;
  assign bus0.zero = zero;
  assign bus0.lt = lt;
  assign bus0.ltu = ltu;
  assign bus0.mem_ready = mem_ready;
  assign bus1.op = op;
  assign bus1.funct3 = funct3;
  assign bus1.funct7b5 = funct7b5;
  assign bus1.zero = zero;
  assign bus1.lt = lt;
  assign bus1.ltu = ltu;
  assign bus1.mem_ready = mem_ready;

  multicycle_controller #(.MEM_HANDSHAKE(1'b1), .TRAP_EN(1'b1), .CNT_W(32)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  multicycle_controller #(.MEM_HANDSHAKE(1'b1), .TRAP_EN(1'b0), .CNT_W(2)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  // {pc_write, ir_write, adr_src, mem_req, mem_write, reg_write,
  //  result_src[1:0], alu_src_a[1:0], alu_src_b[1:0], alu_control[3:0]}
  logic [15:0] obs0;
  logic [15:0] obs1;
  assign obs0 = {bus0.pc_write, bus0.ir_write, bus0.adr_src, bus0.mem_req, bus0.mem_write,
                 bus0.reg_write, bus0.result_src, bus0.alu_src_a, bus0.alu_src_b,
                 bus0.alu_control};
  assign obs1 = {bus1.pc_write, bus1.ir_write, bus1.adr_src, bus1.mem_req, bus1.mem_write,
                 bus1.reg_write, bus1.result_src, bus1.alu_src_a, bus1.alu_src_b,
                 bus1.alu_control};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    #1;
  endtask

  initial begin
    reset_n   = 1'b1;
    mem_ready = 1'b1;
    op        = 7'd0;
    funct3    = 3'd0;
    funct7b5  = 1'b0;
    zero      = 1'b0;
    lt        = 1'b0;
    ltu       = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out", obs0, 16'h0220);
    chk("rst_instret", bus0.instret, 32'd0);
    chk("rst_illegal", bus0.illegal_instr, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // add x3,x1,x2
    instr(7'b0110011, 3'b000, 1'b0);
    chk("add_fetch", obs0, 16'hD220);
    tick(); chk("add_decode", obs0, 16'h0050);
    tick(); chk("add_execr", obs0, 16'h0080);
    tick(); chk("add_aluwb", obs0, 16'h0400);
    chk("add_instret_pre", bus0.instret, 32'd0);
    tick(); chk("add_instret", bus0.instret, 32'd1);

    // sub, srai, addi with bit 30 set
    instr(7'b0110011, 3'b000, 1'b1);
    tick(); tick(); chk("sub_execr", obs0, 16'h0081);
    tick(); tick();
    instr(7'b0010011, 3'b101, 1'b1);
    tick(); tick(); chk("srai_execi", obs0, 16'h0099);
    tick(); tick();
    instr(7'b0010011, 3'b000, 1'b1);
    tick(); tick(); chk("addi_execi", obs0, 16'h0090);
    tick(); tick(); chk("alu_instret", bus0.instret, 32'd4);

    // fetch wait state
    mem_ready = 1'b0; #1;
    chk("fetch_wait", obs0, 16'h1220);
    tick(); chk("fetch_wait_hold", obs0, 16'h1220);
    mem_ready = 1'b1; #1;
    chk("fetch_ready", obs0, 16'hD220);

    // lw with two wait states in MEMREAD
    instr(7'b0000011, 3'b010, 1'b0);
    chk("lw_imm", bus0.imm_src, 3'b000);
    tick(); tick(); chk("lw_memadr", obs0, 16'h0090);
    tick(); chk("lw_memread", obs0, 16'h3000);
    mem_ready = 1'b0;
    tick(); chk("lw_wait1", obs0, 16'h3000);
    tick(); chk("lw_wait2", obs0, 16'h3000);
    mem_ready = 1'b1;
    tick(); chk("lw_memwb", obs0, 16'h0500);
    tick(); chk("lw_fetch", obs0, 16'hD220);
    chk("lw_instret", bus0.instret, 32'd5);

    // sw
    instr(7'b0100011, 3'b010, 1'b0);
    tick(); chk("sw_imm", bus0.imm_src, 3'b001);
    tick(); tick(); chk("sw_memwrite", obs0, 16'h3800);
    tick(); chk("sw_instret", bus0.instret, 32'd6);

    // bltu taken / not taken
    instr(7'b1100011, 3'b110, 1'b0);
    tick(); chk("br_imm", bus0.imm_src, 3'b010);
    tick(); ltu = 1'b1; #1; chk("bltu_taken", obs0, 16'h8081);
    tick(); chk("bltu1_instret", bus0.instret, 32'd7);
    tick(); tick(); ltu = 1'b0; #1; chk("bltu_not", obs0, 16'h0081);
    tick(); chk("bltu0_instret", bus0.instret, 32'd8);

    // bge with lt=1 then lt=0 inside the same BRANCH cycle
    instr(7'b1100011, 3'b101, 1'b0);
    tick(); tick(); lt = 1'b1; #1; chk("bge_lt1", obs0, 16'h0081);
    lt = 1'b0; #1; chk("bge_lt0", obs0, 16'h8081);
    tick();

    // beq zero=1
    instr(7'b1100011, 3'b000, 1'b0);
    tick(); tick(); zero = 1'b1; #1; chk("beq_taken", obs0, 16'h8081);
    zero = 1'b0;
    tick(); chk("br_instret", bus0.instret, 32'd10);

    // jal
    instr(7'b1101111, 3'b000, 1'b0);
    chk("jal_imm", bus0.imm_src, 3'b011);
    tick(); tick(); chk("jal_state", obs0, 16'h8060);
    tick(); chk("jal_aluwb", obs0, 16'h0400);
    tick();

    // jalr
    instr(7'b1100111, 3'b000, 1'b0);
    tick(); tick(); chk("jalr_state", obs0, 16'h8290);
    tick(); chk("jalr_link", obs0, 16'h0060);
    tick(); chk("jalr_aluwb", obs0, 16'h0400);
    tick(); chk("jalr_instret", bus0.instret, 32'd12);
    chk("wrap_instret", bus1.instret, 32'd0);

    // lui, auipc
    instr(7'b0110111, 3'b000, 1'b0);
    chk("lui_imm", bus0.imm_src, 3'b100);
    tick(); tick(); chk("lui_state", obs0, 16'h00D0);
    tick(); tick();
    instr(7'b0010111, 3'b000, 1'b0);
    tick(); tick(); chk("auipc_state", obs0, 16'h0050);
    tick(); tick(); chk("auipc_instret", bus0.instret, 32'd14);
    chk("auipc_instret_w2", bus1.instret, 32'd2);

    // reset during a waiting store
    instr(7'b0100011, 3'b010, 1'b0);
    tick(); tick(); tick(); chk("sw2_memwrite", obs0, 16'h3800);
    mem_ready = 1'b0;
    tick(); chk("sw2_wait_hold", obs0, 16'h3800);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mw_out", obs0, 16'h0220);
    chk("rst_mw_mem_write", bus0.mem_write, 1'b0);
    chk("rst_mw_instret", bus0.instret, 32'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    mem_ready = 1'b1;
    instr(7'b0000000, 3'b000, 1'b0);
    chk("resume_fetch", obs0, 16'hD220);
    tick(); chk("ill_decode", obs0, 16'h0050);
    tick();
    chk("trap_out", obs0, 16'h0000);
    chk("trap_flag", bus0.illegal_instr, 1'b1);
    chk("nop_fetch", obs1, 16'hD220);
    chk("nop_instret", bus1.instret, 32'd1);
    chk("nop_flag", bus1.illegal_instr, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(); chk("trap_hold", obs0, 16'h0000);
    end
    chk("trap_flag_hold", bus0.illegal_instr, 1'b1);
    chk("trap_instret", bus0.instret, 32'd0);
    chk("nop_instret_wrap", bus1.instret, 32'd2);
    chk("nop_fetch_again", obs1, 16'hD220);
    reset_n = 1'b0; #1;
    chk("trap_clear", bus0.illegal_instr, 1'b0);
    chk("trap_rst_out", obs0, 16'h0220);

    // branch with reserved funct3 is illegal
    @(negedge clk);
    reset_n = 1'b1;
    instr(7'b1100011, 3'b010, 1'b0);
    tick(); tick();
    chk("br010_trap", bus0.illegal_instr, 1'b1);
    chk("br010_out", obs0, 16'h0000);
    chk("br010_nop_instret", bus1.instret, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multicycle successor to the single-cycle RISC-V controller. A Moore FSM sequences each RV32I base instruction over 3–5 cycles through a shared-ALU, shared-memory datapath. It adds an optional memory ready handshake, full signed/unsigned branch resolution from dedicated flags, illegal-opcode trapping and a retired-instruction counter. It sits beside the multicycle datapath and drives every enable and mux select in that datapath.

## Interface
- `MEM_HANDSHAKE`, default 1: 1 = memory states wait on `mem_ready`; 0 = `mem_ready` ignored and treated as 1.
- `TRAP_EN`, default 1: 1 = an illegal instruction enters TRAP; 0 = it retires as a NOP and returns to FETCH.
- `CNT_W`, default 32: width of `instret`.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `op` in 7: instruction opcode, from the IR.
- `funct3` in 3: from the IR.
- `funct7b5` in 1: bit 30 of the IR.
- `zero` in 1: ALU result == 0.
- `lt` in 1: signed rs1 < rs2.
- `ltu` in 1: unsigned rs1 < rs2.
- `mem_ready` in 1: memory has completed the current access.
- `pc_write` out 1: PC load enable.
- `ir_write` out 1: IR/oldPC load enable.
- `adr_src` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_req` out 1: memory access request.
- `mem_write` out 1: store strobe.
- `reg_write` out 1: register file write enable.
- `result_src` out 2: Result mux select; 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alu_src_a` out 2: ALU A select; 00 = PC, 01 = oldPC, 10 = A, 11 = zero.
- `alu_src_b` out 2: ALU B select; 00 = B, 01 = ImmExt, 10 = 4.
- `imm_src` out 3: immediate format; I = 000, S = 001, B = 010, J = 011, U = 100.
- `alu_control` out 4: ALU operation code.
- `illegal_instr` out 1: sticky trap flag.
- `instret` out CNT_W: retired-instruction count.

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LINK, LUI, AUIPC, TRAP.
- **FETCH:** `mem_req`=1, `adr_src`=0, A=PC, B=4, ALUOp add, `result_src`=10.
  - When ready: assert `ir_write` and `pc_write`, then go to DECODE.
  - When not ready: hold in FETCH with both enables low.
- **DECODE:** A=oldPC, B=Imm, add (precomputes the branch/JAL target into ALUOut). Next state by `op`:
  - 0000011 → MEMADR
  - 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - any other opcode, or a branch with `funct3` 010/011 → illegal
- **MEMADR:** A=A, B=Imm, add. Loads go to MEMREAD; stores go to MEMWRITE.
- **MEMREAD:** `mem_req`, `adr_src`=1. Moves to MEMWB when ready.
- **MEMWB:** `result_src`=01, `reg_write`. Then FETCH.
- **MEMWRITE:** `mem_req`, `adr_src`=1. `mem_write` stays high while waiting. Moves to FETCH when ready.
- **EXECR / EXECI:** A=A, B=B or Imm, ALUOp funct. Then ALUWB.
- **ALUWB:** `result_src`=00, `reg_write`. Then FETCH.
- **BRANCH:** A=A, B=B, sub, `result_src`=00. Then FETCH. `pc_write` = take, where take is:
  - 000: `zero`
  - 001: `!zero`
  - 100: `lt`
  - 101: `!lt`
  - 110: `ltu`
  - 111: `!ltu`
- **JAL:** A=oldPC, B=4, add, `result_src`=00, `pc_write`. Then ALUWB.
- **JALR:** A=A, B=Imm, add, `result_src`=10, `pc_write`. Then LINK.
- **LINK:** A=oldPC, B=4, add. Then ALUWB.
- **LUI / AUIPC:** A = zero or oldPC, B=Imm, add. Then ALUWB.
- **TRAP:** all enables 0. Held until reset.
- **Illegal instruction:**
  - `TRAP_EN`=1: set `illegal_instr` and go to TRAP.
  - `TRAP_EN`=0: return to FETCH and count the instruction as retired.
- **`alu_control`** (add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sltu 0110, sll 0111, srl 1000, sra 1001):
  - ALUOp add → add; ALUOp sub → sub.
  - ALUOp funct, by `funct3`:
    - 000: sub if `op[5]` & `funct7b5`, else add
    - 001: sll
    - 010: slt
    - 011: sltu
    - 100: xor
    - 101: sra if `funct7b5`, else srl
    - 110: or
    - 111: and
- **`imm_src`:** combinational from `op` in every state (I-format for loads, JALR and I-ALU instructions).
- **`instret`:** increments on every transition into FETCH from a non-FETCH state, and wraps modulo 2^CNT_W.

## Timing
- **Reset:** while `reset_n`=0, the state is FETCH, `instret`=0 and `illegal_instr`=0. `pc_write`, `ir_write`, `reg_write`, `mem_req` and `mem_write` are forced to 0; the other outputs show FETCH decoding. Reset asserted mid-instruction aborts it with no write.
- **Output timing:** all outputs are Moore except `pc_write` in BRANCH and the ready-gated enables, which are combinational on flags and `mem_ready`.
- **Latency with zero wait states:**
  - branch: 3 cycles
  - R, I, store, JAL, LUI, AUIPC: 4 cycles
  - load, JALR: 5 cycles
- **Wait states:** each low-`mem_ready` cycle in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs are held stable during the wait.
- **First fetch:** begins on the first edge after `reset_n` rises.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state enum
  - ALUOp, `alu_control`, `imm_src`, `result_src` and `alu_src` encodings
  - opcode constants
- Sub-module `mc_alu_decoder` is the combinational ALUOp/`funct3`/`funct7b5`/`op[5]` → `alu_control` decoder.
- The FSM, output decode, branch resolution and counter live in the top module.

## Test plan
- **add x3,x1,x2 (0x002081B3), `mem_ready`=1:** the state sequence is FETCH, DECODE, EXECR, ALUWB, with `alu_control`=0000 in EXECR and `reg_write`=1 in cycle 4; `instret` reads 1 after that.
- **lw with `mem_ready` low for 2 cycles in MEMREAD:** takes 7 cycles; `reg_write` is asserted once, in MEMWB, with `result_src`=01.
- **bltu for each `ltu` value, and bge with `lt`=1:** `pc_write`=1 only for bltu with `ltu`=1; both cases take 3 cycles.
- **jalr:** `pc_write` is asserted in JALR with `result_src`=10; LINK uses A=01, B=10; then ALUWB; 5 cycles total.
- **Opcode 0000000:**
  - `TRAP_EN`=1: TRAP is entered, `illegal_instr`=1, no enables for 10 cycles, and `reset_n` low clears it.
  - `TRAP_EN`=0: FETCH follows DECODE and `instret` increments.
- **`reset_n` dropped during MEMWRITE with `mem_write`=1:** `mem_write` falls immediately (asynchronously) and FETCH resumes after release.
